// File: rtl/port_stim_gen.sv
// Pseudo-random operand generator for exercising a port under test.
// An LFSR supplies each operand transaction, and a MISR folds the returned results into a signature.
module port_stim_gen #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [15:0]       txn_count,
    input  logic [31:0]       seed,
    output logic [CTRL_W-1:0] control_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    input  logic              ready_in,
    input  logic [DATA_W-1:0] result_in,
    input  logic              result_valid_in,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       signature,
    output logic [15:0]       txn_sent,
    output logic [15:0]       results_seen
);

    localparam int OP_W = 2*DATA_W + CTRL_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [15:0]     r_count;
    logic [31:0]     r_seed;
    logic [31:0]     r_lfsr;
    logic [7:0]      r_idle;
    logic [OP_W-1:0] r_ops;
    logic            r_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_timeout;
    logic [15:0]     r_sig;
    logic [15:0]     r_sent;
    logic [15:0]     r_seen;

    logic [31:0]     w_lfsr_init;
    logic [31:0]     w_lfsr_step;
    logic            w_xfer;
    logic            w_res;
    logic [15:0]     w_sig_next;
    logic [15:0]     w_seen_next;

    assign w_lfsr_init = (r_seed == 32'h0) ? 32'h1 : r_seed;
    assign w_lfsr_step = (r_lfsr >> 1) ^ (r_lfsr[0] ? 32'hA300_0000 : 32'h0);
    assign w_xfer      = r_valid & ready_in;
    // Results only count while a run is actively sending or draining.
    assign w_res       = result_valid_in & ((r_state == S_SEND) || (r_state == S_DRAIN));
    assign w_sig_next  = {r_sig[14:0], r_sig[15] ^ r_sig[14] ^ r_sig[12] ^ r_sig[3]}
                         ^ 16'(result_in);
    assign w_seen_next = (r_seen == 16'hFFFF) ? r_seen : r_seen + 16'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_seed    <= '0;
            r_lfsr    <= 32'h1;
            r_idle    <= '0;
            r_ops     <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_sig     <= '0;
            r_sent    <= '0;
            r_seen    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_res) begin
                r_sig  <= w_sig_next;
                r_seen <= w_seen_next;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_LOAD;
                        r_count   <= txn_count;
                        r_seed    <= seed;
                        r_sig     <= '0;
                        r_sent    <= '0;
                        r_seen    <= '0;
                        r_timeout <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_lfsr <= w_lfsr_init;
                    r_ops  <= w_lfsr_init[OP_W-1:0];
                    r_idle <= '0;
                    if (r_count == 16'd0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_SEND;
                        r_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    // Operands only move on a transfer, so they stay put while stalled.
                    if (w_xfer) begin
                        r_lfsr <= w_lfsr_step;
                        r_ops  <= w_lfsr_step[OP_W-1:0];
                        r_sent <= r_sent + 16'd1;
                        if (r_sent + 16'd1 == r_count) begin
                            r_valid <= 1'b0;
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_seen == r_count) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_res) begin
                        r_idle <= '0;
                    end else if (r_idle == 8'd254) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end else begin
                        r_idle <= r_idle + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign control_out  = r_ops[OP_W-1:2*DATA_W];
    assign b_out        = r_ops[2*DATA_W-1:DATA_W];
    assign a_out        = r_ops[DATA_W-1:0];
    assign valid_out    = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign signature    = r_sig;
    assign txn_sent     = r_sent;
    assign results_seen = r_seen;

endmodule

// File: tb/tb_port_stim_gen.sv
// Scoreboard bench for port_stim_gen: expected operands are queued at start and popped on each
// transfer. A responder echoes a result one cycle later and tracks the expected signature.
module tb_port_stim_gen;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] txn_count = '0;
    logic [31:0] seed = '0;
    logic [1:0]  control_out;
    logic [7:0]  a_out;
    logic [7:0]  b_out;
    logic        valid_out;
    logic        ready_in;
    logic [7:0]  result_in;
    logic        result_valid_in;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] signature;
    logic [15:0] txn_sent;
    logic [15:0] results_seen;

    port_stim_gen #(.DATA_W(8), .CTRL_W(2)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .txn_count       (txn_count),
        .seed            (seed),
        .control_out     (control_out),
        .a_out           (a_out),
        .b_out           (b_out),
        .valid_out       (valid_out),
        .ready_in        (ready_in),
        .result_in       (result_in),
        .result_valid_in (result_valid_in),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .signature       (signature),
        .txn_sent        (txn_sent),
        .results_seen    (results_seen)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'hA300_0000 : 32'h0);
    endfunction

    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [7:0] r);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {8'h00, r};
    endfunction

    // Scoreboard and monitor state
    logic [31:0] q_ops[$];
    logic [31:0] exp_op;
    logic [31:0] first_op;
    logic [15:0] exp_sig;
    int          exp_seen;
    int          n_tx, n_valid, n_done, n_drain;
    int          stall_at, stall_left, echo_limit, run_count;
    int          cyc, first_cyc, last_cyc;
    bit          stalled, mon_en, pend_v, new_v;
    logic [7:0]  pend_d, new_d;

    initial begin
        ready_in = 1'b1;
        result_valid_in = 1'b0;
        result_in = '0;
        mon_en = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (!mon_en) begin
                ready_in = 1'b1;
                result_valid_in = 1'b0;
                pend_v = 1'b0;
            end else begin
                new_v = 1'b0;
                new_d = '0;
                if (done) n_done++;
                if (busy && !valid_out && run_count > 0 && n_tx == run_count) n_drain++;
                if (valid_out && !stalled && n_tx == stall_at) begin
                    stalled = 1'b1;
                    stall_left = 3;
                end
                ready_in = (stall_left == 0);
                if (valid_out) begin
                    n_valid++;
                    if (q_ops.size() == 0) begin
                        chk("extra_valid", {31'b0, valid_out}, 32'h0);
                    end else if (!ready_in) begin
                        chk("stall_ops", {14'b0, control_out, b_out, a_out}, q_ops[0]);
                        chk("stall_sent", {16'b0, txn_sent}, n_tx);
                        stall_left--;
                    end else begin
                        exp_op = q_ops.pop_front();
                        chk("op", {14'b0, control_out, b_out, a_out}, exp_op);
                        if (n_tx == 0) first_op = {14'b0, control_out, b_out, a_out};
                        n_tx++;
                        if (n_tx == 1) first_cyc = cyc;
                        last_cyc = cyc;
                        if (n_tx <= echo_limit) begin
                            new_v = 1'b1;
                            new_d = (a_out + b_out) ^ {6'b0, control_out};
                        end
                    end
                end
                result_valid_in = pend_v;
                result_in = pend_d;
                if (pend_v) begin
                    exp_sig = sig_step(exp_sig, pend_d);
                    exp_seen++;
                end
                pend_v = new_v;
                pend_d = new_d;
            end
        end
    end

    // Called at a negedge; start goes high immediately so the next rising edge samples it.
    task automatic run(input int cnt, input logic [31:0] sd, input int st_at, input int echo_lim,
                       input bit restart, input int abort_at,
                       output int lat, output logic [15:0] sig_out);
        logic [31:0] l;
        int exp_res;
        q_ops.delete();
        n_tx = 0; n_valid = 0; n_done = 0; n_drain = 0;
        stall_at = st_at; stall_left = 0; stalled = 1'b0;
        echo_limit = echo_lim; exp_sig = '0; exp_seen = 0; pend_v = 1'b0;
        run_count = cnt; first_op = '1; first_cyc = 0; last_cyc = 0;
        l = (sd == 32'h0) ? 32'h1 : sd;
        for (int i = 0; i < cnt; i++) begin
            q_ops.push_back({14'b0, l[17:0]});
            l = lfsr_step(l);
        end
        mon_en = 1'b1;
        txn_count = cnt[15:0];
        seed = sd;
        start = 1'b1;
        lat = 0;
        sig_out = '0;
        while (lat < 2000) begin
            @(negedge clock);
            lat++;
            start = (restart && lat == 5);
            if (abort_at >= 0 && txn_sent == abort_at[15:0]) break;
            if (abort_at < 0 && done) break;
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            chk("abort_reach", {16'b0, txn_sent}, abort_at);
            mon_en = 1'b0;
            #2 reset_n = 1'b0;
            #1;
            chk("rst_flags", {28'b0, valid_out, busy, done, timeout}, 32'h0);
            chk("rst_ops", {14'b0, control_out, b_out, a_out}, 32'h0);
            chk("rst_sig", {16'b0, signature}, 32'h0);
            chk("rst_cnt", {txn_sent, results_seen}, 32'h0);
            @(negedge clock);
            reset_n = 1'b1;
            return;
        end
        exp_res = (echo_lim < cnt) ? echo_lim : cnt;
        chk("done_seen", {31'b0, done}, 32'h1);
        chk("txn_sent", {16'b0, txn_sent}, cnt);
        chk("results_seen", {16'b0, results_seen}, exp_res);
        chk("exp_seen", {16'b0, results_seen}, exp_seen);
        chk("signature", {16'b0, signature}, {16'b0, exp_sig});
        chk("timeout", {31'b0, timeout}, {31'b0, (echo_lim < cnt)});
        chk("busy_at_done", {31'b0, busy}, 32'h0);
        chk("ops_left", q_ops.size(), 32'h0);
        @(negedge clock);
        chk("done_pulse", {31'b0, done}, 32'h0);
        chk("done_count", n_done, 32'h1);
        chk("hold_sig", {16'b0, signature}, {16'b0, exp_sig});
        chk("hold_sent", {16'b0, txn_sent}, cnt);
        sig_out = signature;
        mon_en = 1'b0;
    endtask

    int          lat;
    logic [15:0] sig_a, sig_b, sig_x;

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_flags", {28'b0, valid_out, busy, done, timeout}, 32'h0);
        chk("reset_ops", {14'b0, control_out, b_out, a_out}, 32'h0);
        chk("reset_cnt", {signature, txn_sent | results_seen}, 32'h0);
        reset_n = 1'b1;

        // Basic run: seed 1, back-to-back transfers, start accepted on first edge after reset
        run(4, 32'h1, -1, 1000, 1'b0, -1, lat, sig_a);
        chk("first_op", first_op, 32'h0000_0001);
        chk("back_to_back", last_cyc - first_cyc, 32'd3);
        chk("valid_cycles", n_valid, 32'd4);
        chk("latency_4", lat, 32'd8);

        // Stall of 3 cycles mid-SEND plus a start pulse while busy
        run(8, 32'hDEAD_BEEF, 3, 1000, 1'b1, -1, lat, sig_x);
        chk("stall_valid_cycles", n_valid, 32'd11);

        // Zero-length run
        run(0, 32'h5, -1, 1000, 1'b0, -1, lat, sig_x);
        chk("zero_latency", lat, 32'd2);
        chk("zero_valid", n_valid, 32'd0);

        // Only one result returned: drain timeout
        run(2, 32'h7, -1, 1, 1'b0, -1, lat, sig_x);
        chk("drain_cycles", n_drain, 32'd255);

        // Asynchronous reset during SEND, then a normal run
        run(10, 32'h1234_5678, -1, 1000, 1'b0, 3, lat, sig_x);
        run(4, 32'h1, -1, 1000, 1'b0, -1, lat, sig_x);
        chk("post_reset_latency", lat, 32'd8);

        // Seed 0 behaves as seed 1
        run(4, 32'h0, -1, 1000, 1'b0, -1, lat, sig_b);
        chk("seed0_first_op", first_op, 32'h0000_0001);
        chk("seed0_signature", {16'b0, sig_b}, {16'b0, sig_a});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/port_stim_gen.md
PORT_STIM_GEN -- requirements
Module: port_stim_gen

Interface
Parameters:
REQ-001 SHALL have parameter DATA_W, default 8, meaning the operand width of a_out, b_out and result_in.
REQ-002 SHALL have parameter CTRL_W, default 2, meaning the width of control_out; 2*DATA_W+CTRL_W <= 32 is required.
Ports:
REQ-003 SHALL have port clock  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port start  input  1  pulse to begin a run; sampled only in IDLE.
REQ-006 SHALL have port txn_count  input  16  number of operand transactions per run; latched on start.
REQ-007 SHALL have port seed  input  32  LFSR seed; latched on start.
REQ-008 SHALL have port control_out  output  CTRL_W  operation select to the port under test.
REQ-009 SHALL have port a_out  output  DATA_W  operand A.
REQ-010 SHALL have port b_out  output  DATA_W  operand B.
REQ-011 SHALL have port valid_out  output  1  operand transaction valid.
REQ-012 SHALL have port ready_in  input  1  port under test accepts the transaction.
REQ-013 SHALL have port result_in  input  DATA_W  result returned by the port under test.
REQ-014 SHALL have port result_valid_in  input  1  result_in valid this cycle.
REQ-015 SHALL have port busy  output  1  run in progress (LOAD, SEND or DRAIN).
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-017 SHALL have port timeout  output  1  sticky; last run ended by drain timeout.
REQ-018 SHALL have port signature  output  16  MISR over received results.
REQ-019 SHALL have port txn_sent  output  16  transfers completed this run.
REQ-020 SHALL have port results_seen  output  16  results received this run.

Function
REQ-021 SHALL implement FSM IDLE -> LOAD -> SEND -> DRAIN -> DONE -> IDLE.
REQ-022 IDLE: start=1 -> LOAD; latch txn_count and seed; clear signature, txn_sent, results_seen and timeout.
REQ-023 LOAD: one cycle; lfsr <= (seed==0 ? 32'h1 : seed); go to SEND, or to DONE if latched txn_count==0.
REQ-024 SEND: valid_out=1; a_out=lfsr[DATA_W-1:0], b_out=lfsr[2*DATA_W-1:DATA_W], control_out=lfsr[2*DATA_W+CTRL_W-1:2*DATA_W].
REQ-025 Transfer occurs on valid_out&ready_in; on transfer the LFSR advances one step and txn_sent increments, giving back-to-back throughput of 1 transfer/cycle.
REQ-026 While valid_out=1 and ready_in=0, control_out, a_out and b_out SHALL be held stable.
REQ-027 LFSR step: Galois right shift; lfsr_next = (lfsr>>1) ^ (lfsr[0] ? 32'hA3000000 : 0).
REQ-028 The transfer that makes txn_sent==txn_count -> DRAIN with valid_out=0 in the next cycle.
REQ-029 When result_valid_in=1 in SEND or DRAIN: results_seen++ (saturating at 16'hFFFF), signature <= {sig[14:0], sig[15]^sig[14]^sig[12]^sig[3]} ^ zero-extended result_in.
REQ-030 result_valid_in in IDLE, LOAD or DONE SHALL be ignored.
REQ-031 DRAIN: results_seen==txn_count -> DONE; otherwise a 8-bit idle counter counts cycles with no result and resets on each result; 255 consecutive idle cycles -> DONE with timeout=1.
REQ-032 DONE: done=1 for exactly one cycle; -> IDLE; counters and signature hold until the next start.
REQ-033 A result arriving in the same cycle as the last transfer SHALL be counted.
REQ-034 start asserted while busy=1 SHALL be ignored.
REQ-035 busy=1 exactly in LOAD, SEND and DRAIN.

Reset
REQ-036 reset_n=0 SHALL immediately force IDLE, with valid_out, done, busy and timeout at 0, control_out, a_out and b_out at 0, signature, txn_sent and results_seen at 0, and lfsr at 32'h1, regardless of state.
REQ-037 After reset_n deasserts, the first start is accepted on the first rising edge.

Verification
REQ-038 txn_count=4, seed=32'h1, ready_in=1, results echoed 1 cycle after each transfer -> first transfer presents a_out=8'h01, b_out=8'h00, control_out=0; 4 transfers on consecutive cycles; results_seen=4; done pulses once; timeout=0.
REQ-039 ready_in held 0 for 3 cycles mid-SEND -> valid_out stays 1; control_out, a_out and b_out unchanged; txn_sent unchanged until ready_in=1.
REQ-040 txn_count=0 -> LOAD then DONE; done 2 cycles after start; txn_sent=0; valid_out never asserted.
REQ-041 txn_count=2, only 1 result returned -> done after 255 idle DRAIN cycles; timeout=1; results_seen=1.
REQ-042 reset_n pulsed low during SEND with txn_sent=3 -> all outputs 0 asynchronously; a new start then runs normally from txn_sent=0.
REQ-043 seed=0 vs seed=32'h1 with identical result stream -> identical operand sequence and identical final signature.
